// File: rtl/up_mem_if.sv
// Memory bus interface: turns each controller request into one address/strobe
// cycle on a non-multiplexed external bus, with wait states and a bounded timeout.
module up_mem_if #(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int WAIT_MIN = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rdy,
  output logic          err,
  output logic [AW-1:0] ext_addr,
  output logic          ext_ale,
  output logic          ext_rd_n,
  output logic          ext_wr_n,
  output logic [DW-1:0] ext_dout,
  output logic          ext_doe,
  input  logic [DW-1:0] ext_din,
  input  logic          ext_wait
);

  localparam int CMAX = WAIT_MIN + TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] CMAX_C = CW'(CMAX);
  localparam logic [CW:0]   CMAX_W = (CW+1)'(CMAX);
  localparam logic [CW:0]   WMIN_W = (CW+1)'(WAIT_MIN);

  typedef enum logic [1:0] {IDLE, ADDR, STROBE, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   elapsed_s;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rdy_q, rdy_d;
  logic          err_q, err_d;
  logic          ale_q, ale_d;
  logic          rd_n_q, rd_n_d;
  logic          wr_n_q, wr_n_d;
  logic          doe_q, doe_d;

  // Next-state logic; bus outputs are precomputed from the next state so they
  // leave the block straight from flops.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    // Strobe cycles elapsed including the current one.
    elapsed_s = {1'b0, cnt_q} + (CW+1)'(1);
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = '0;
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: state_d = STROBE;
      STROBE: begin
        cnt_d = (cnt_q == CMAX_C) ? cnt_q : cnt_q + CW'(1);
        if ((elapsed_s >= WMIN_W) && !ext_wait) begin
          state_d = DONE;
          if (!we_q) rdata_d = ext_din;
          else       rdata_d = rdata_q;
        end else if (elapsed_s >= CMAX_W) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (!we_q) rdata_d = '1;
          else       rdata_d = rdata_q;
        end else begin
          state_d = STROBE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ale_d  = (state_d == ADDR);
    rd_n_d = !((state_d == STROBE) && !we_d);
    wr_n_d = !((state_d == STROBE) && we_d);
    doe_d  = (state_d == STROBE) && we_d;
    rdy_d  = (state_d == DONE);
  end

  // State, latched transaction fields and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      ale_q   <= 1'b0;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      doe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      ale_q   <= ale_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      doe_q   <= doe_d;
    end
  end

  assign rdata    = rdata_q;
  assign rdy      = rdy_q;
  assign err      = err_q;
  assign ext_addr = addr_q;
  assign ext_dout = wdata_q;
  assign ext_ale  = ale_q;
  assign ext_rd_n = rd_n_q;
  assign ext_wr_n = wr_n_q;
  assign ext_doe  = doe_q;

endmodule

// File: tb/tb_up_mem_if.sv
// Randomized self-checking bench for up_mem_if against a transaction-level model.
module tb_up_mem_if;

  localparam int AW = 16, DW = 8, WMIN = 1, TMO = 15;
  localparam int CMAX = WMIN + TMO;

  logic          clk = 1'b0;
  logic          rst, req, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata, ext_dout, ext_din;
  logic          rdy, err, ext_ale, ext_rd_n, ext_wr_n, ext_doe, ext_wait;
  logic [AW-1:0] ext_addr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_rdata;
  bit            wait_seq [1:CMAX];
  logic [DW-1:0] din_seq  [1:CMAX];

  up_mem_if #(.AW(AW), .DW(DW), .WAIT_MIN(WMIN), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rdy(rdy), .err(err), .ext_addr(ext_addr), .ext_ale(ext_ale),
    .ext_rd_n(ext_rd_n), .ext_wr_n(ext_wr_n), .ext_dout(ext_dout), .ext_doe(ext_doe),
    .ext_din(ext_din), .ext_wait(ext_wait)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe length is the first cycle k >= WAIT_MIN with wait low, else the timeout limit.
  task automatic ref_model(output int len, output bit terr);
    bit found;
    found = 1'b0;
    len   = CMAX;
    terr  = 1'b1;
    for (int k = 1; k <= CMAX; k++) begin
      if (!found && k >= WMIN && !wait_seq[k]) begin
        found = 1'b1;
        len   = k;
        terr  = 1'b0;
      end
    end
  endtask

  // mode 0: no waits, 1: wait high for the first n strobe cycles, 2: stuck, 3: random
  task automatic set_waits(input int mode, input int n);
    for (int k = 1; k <= CMAX; k++) begin
      din_seq[k] = DW'($urandom);
      case (mode)
        0:       wait_seq[k] = 1'b0;
        1:       wait_seq[k] = (k <= n);
        2:       wait_seq[k] = 1'b1;
        default: wait_seq[k] = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_txn(input bit t_we, input logic [AW-1:0] t_addr,
                         input logic [DW-1:0] t_wdata, input bit hold);
    int len;
    bit terr, strobe;
    logic [5:0] exp_v, obs_v;
    ref_model(len, terr);
    req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
    ext_wait = 1'b1; ext_din = DW'($urandom);
    for (int t = 1; t <= len + 3; t++) begin
      @(posedge clk); @(negedge clk);
      if (t == 1) begin
        req = hold; we = ~t_we; addr = AW'($urandom); wdata = DW'($urandom);
      end
      strobe = (t >= 2) && (t <= len + 1);
      exp_v = {t == 1, !(strobe && !t_we), !(strobe && t_we), strobe && t_we,
               t == len + 2, (t == len + 2) && terr};
      obs_v = {ext_ale, ext_rd_n, ext_wr_n, ext_doe, rdy, err};
      check($sformatf("ctl a=%0h we=%0d t=%0d", t_addr, t_we, t), 32'(obs_v), 32'(exp_v));
      check($sformatf("ext_addr t=%0d", t), 32'(ext_addr), 32'(t_addr));
      if (strobe && t_we) check("ext_dout", 32'(ext_dout), 32'(t_wdata));
      if (t == len + 2 && !t_we) exp_rdata = terr ? {DW{1'b1}} : din_seq[len];
      if (t >= len + 2) check($sformatf("rdata t=%0d", t), 32'(rdata), 32'(exp_rdata));
      if (t >= 2 && t - 1 <= CMAX) begin
        ext_wait = wait_seq[t-1];
        ext_din  = din_seq[t-1];
      end else begin
        ext_wait = 1'($urandom);
        ext_din  = DW'($urandom);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    ext_wait = 1'b0; ext_din = '0; exp_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ctl", 32'({ext_ale, ext_rd_n, ext_wr_n, ext_doe, rdy, err}), 32'(6'b011000));
    check("reset ext_addr", 32'(ext_addr), 32'h0);
    check("reset ext_dout", 32'(ext_dout), 32'h0);
    check("reset rdata", 32'(rdata), 32'h0);
    rst = 1'b0;

    // Zero-wait read, write, wait states, timeout, and wait dropping at the limit.
    set_waits(0, 0); din_seq[1] = 8'hA5;
    run_txn(1'b0, 16'h1234, 8'h00, 1'b0);
    check("read data A5", 32'(rdata), 32'hA5);
    set_waits(0, 0);
    run_txn(1'b1, 16'h00FF, 8'h3C, 1'b0);
    check("write keeps rdata", 32'(rdata), 32'hA5);
    set_waits(1, 3);
    run_txn(1'b0, 16'h4321, 8'h00, 1'b0);
    set_waits(2, 0);
    run_txn(1'b0, 16'h5555, 8'h00, 1'b0);
    check("timeout rdata", 32'(rdata), 32'hFF);
    set_waits(1, CMAX - 1);
    run_txn(1'b0, 16'h6666, 8'h00, 1'b0);
    set_waits(2, 0);
    run_txn(1'b1, 16'h7777, 8'h99, 1'b0);

    // Back-to-back reads with req held high.
    for (int i = 0; i < 3; i++) begin
      set_waits(0, 0);
      run_txn(1'b0, AW'(i), 8'h00, i < 2);
    end

    // Reset in the middle of a read strobe.
    req = 1'b1; we = 1'b0; addr = 16'hBEEF; ext_wait = 1'b1;
    @(posedge clk); @(negedge clk);
    req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid strobe rd_n", 32'(ext_rd_n), 32'h0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("mid reset ctl", 32'({ext_ale, ext_rd_n, ext_wr_n, ext_doe, rdy, err}), 32'(6'b011000));
    check("mid reset ext_addr", 32'(ext_addr), 32'h0);
    check("mid reset rdata", 32'(rdata), 32'h0);
    rst = 1'b0; exp_rdata = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      check("no rdy after reset", 32'({rdy, ext_rd_n}), 32'(2'b01));
    end
    set_waits(0, 0);
    run_txn(1'b0, 16'h0ABC, 8'h00, 1'b0);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      set_waits($urandom_range(0, 3), $urandom_range(0, CMAX));
      run_txn(1'($urandom), AW'($urandom), DW'($urandom), (i < 39) && ($urandom_range(0, 1) == 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
